io_handshake_responder: RTL and testbench

- Peripheral-side responder for the CPU's blocking I/O protocol.
- The control unit raises is_input or is_output and stalls until confirmation is returned. This block does the rest: it latches the output value to the display, waits for a debounced user press/release of the continue button, samples the switches for input requests, and returns confirmation.
- A button press while no I/O request is pending produces a one-cycle is_user_request pulse toward the instruction decoder.

---
 rtl/io_handshake_responder_pkg.sv | 18 +
 rtl/io_handshake_responder_if.sv | 29 ++
 rtl/io_handshake_responder_button_debouncer.sv | 58 +++++
 rtl/io_handshake_responder.sv | 106 ++++++++++
 tb/tb_io_handshake_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_handshake_responder_pkg.sv
// Shared types and default sizing for the I/O handshake responder.
package io_handshake_responder_pkg;

    localparam int DEFAULT_DATA_WIDTH      = 32;
    localparam int DEFAULT_SWITCH_WIDTH    = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_COUNTER_WIDTH   = 16;

    // Handshake progress: a request waits for a full debounced press/release
    // of the continue button before confirmation is returned.
    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        WAIT_RELEASE,
        CONFIRM
    } state_t;

endpackage

// File: rtl/io_handshake_responder_if.sv
// CPU/board-facing signal bundle of the responder. The master side is the
// CPU control unit plus the board inputs; the slave side is the responder.
interface io_handshake_responder_if
    import io_handshake_responder_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int SWITCH_WIDTH = DEFAULT_SWITCH_WIDTH
);
    logic                    is_input;
    logic                    is_output;
    logic [DATA_WIDTH-1:0]   data_out;
    logic [SWITCH_WIDTH-1:0] switches;
    logic                    continue_button;
    logic                    confirmation;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   display_value;
    logic                    is_user_request;
    logic                    busy;

    modport master (
        output is_input, is_output, data_out, switches, continue_button,
        input  confirmation, data_in, display_value, is_user_request, busy
    );

    modport slave (
        input  is_input, is_output, data_out, switches, continue_button,
        output confirmation, data_in, display_value, is_user_request, busy
    );
endinterface

// File: rtl/io_handshake_responder_button_debouncer.sv
// Synchronizes the raw continue button, accepts a level change only after
// DEBOUNCE_CYCLES consecutive differing samples, and emits one-cycle
// strobes on the accepted rising and falling edges.
module io_handshake_responder_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press_evt,
    output logic release_evt
);
    localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                     button_meta;
    logic                     button_sync;
    logic                     level;
    logic [COUNTER_WIDTH-1:0] count;

    // Two-flop synchronizer for the asynchronous button input.
    // NOTE: every flop here is reset, synchronizer included, so a button held
    // through reset is seen as a fresh press that must re-debounce from 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            button_meta <= 1'b0;
            button_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking so both stages sample the pre-edge values and
            // the chain really is two flops deep.
            button_meta <= button;
            button_sync <= button_meta;
        end
    end

    // Stability counter; toggles the debounced level and strobes the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level       <= 1'b0;
            count       <= '0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
            if (button_sync == level) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                level       <= ~level;
                count       <= '0;
                press_evt   <= ~level;
                release_evt <= level;
            end else begin
                count <= count + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_handshake_responder.sv
// Peripheral-side responder for the CPU's blocking I/O protocol: latches
// output values to the display, captures switches for input requests, and
// confirms once the user has pressed and released the continue button.
module io_handshake_responder
    import io_handshake_responder_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int SWITCH_WIDTH    = DEFAULT_SWITCH_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int COUNTER_WIDTH   = DEFAULT_COUNTER_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    io_handshake_responder_if.slave bus
);
    state_t                  state;
    logic                    press_evt;
    logic                    release_evt;
    logic                    req;
    logic [SWITCH_WIDTH-1:0] switches_meta;
    logic [SWITCH_WIDTH-1:0] switches_sync;

    assign req = bus.is_input | bus.is_output;

    io_handshake_responder_button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .COUNTER_WIDTH   (COUNTER_WIDTH)
    ) u_button_debouncer (
        .clock       (clock),
        .reset       (reset),
        .button      (bus.continue_button),
        .press_evt   (press_evt),
        .release_evt (release_evt)
    );

    // Two-flop synchronizer for the switch bank; only sampled at capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            switches_meta <= '0;
            switches_sync <= '0;
        end else begin
            switches_meta <= bus.switches;
            switches_sync <= switches_meta;
        end
    end

    // Handshake FSM with registered outputs; a withdrawn request aborts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            bus.confirmation    <= 1'b0;
            bus.data_in         <= '0;
            bus.display_value   <= '0;
            bus.is_user_request <= 1'b0;
            bus.busy            <= 1'b0;
        end else begin
            bus.is_user_request <= 1'b0;
            case (state)
                IDLE: begin
                    // A press coinciding with a new request is swallowed.
                    if (req) begin
                        state    <= WAIT_PRESS;
                        bus.busy <= 1'b1;
                        if (bus.is_output) begin
                            bus.display_value <= bus.data_out;
                        end
                    end else if (press_evt) begin
                        bus.is_user_request <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    if (!req) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (press_evt) begin
                        state <= WAIT_RELEASE;
                        if (bus.is_input) begin
                            bus.data_in <= DATA_WIDTH'(switches_sync);
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (!req) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (release_evt) begin
                        state            <= CONFIRM;
                        bus.confirmation <= 1'b1;
                    end
                end
                CONFIRM: begin
                    if (!req) begin
                        state            <= IDLE;
                        bus.confirmation <= 1'b0;
                        bus.busy         <= 1'b0;
                    end
                end
                default: begin
                    state            <= IDLE;
                    bus.confirmation <= 1'b0;
                    bus.busy         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_io_handshake_responder.sv
// Self-checking bench for io_handshake_responder with a short debounce.
module tb_io_handshake_responder;
    localparam int DW  = 32;
    localparam int SW  = 16;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    io_handshake_responder_if #(.DATA_WIDTH(DW), .SWITCH_WIDTH(SW)) bus ();

    io_handshake_responder #(
        .DATA_WIDTH      (DW),
        .SWITCH_WIDTH    (SW),
        .DEBOUNCE_CYCLES (DEB),
        .COUNTER_WIDTH   (4)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Protocol progress as the user sees it: waiting for the button to go
    // down, waiting for it to come back up, or done and awaiting withdrawal.
    typedef enum {PH_IDLE, PH_WANT_DOWN, PH_WANT_UP, PH_DONE} phase_t;

    phase_t        m_phase;
    logic          m_stable;          // accepted button level
    int            m_run;             // samples in a row disagreeing with it
    logic          m_down_seen, m_up_seen;
    logic          raw_btn [2];       // [1] is the raw value two edges ago
    logic [SW-1:0] raw_sw  [2];
    logic          m_user;
    logic [DW-1:0] m_din, m_disp;

    task automatic model_tick();
        logic          seen_btn;
        logic [SW-1:0] seen_sw;
        logic          down_now, up_now, want;
        if (rst) begin
            m_phase = PH_IDLE; m_stable = 0; m_run = 0;
            m_down_seen = 0; m_up_seen = 0;
            raw_btn[0] = 0; raw_btn[1] = 0; raw_sw[0] = '0; raw_sw[1] = '0;
            m_user = 0; m_din = '0; m_disp = '0;
            return;
        end
        seen_btn = raw_btn[1];
        seen_sw  = raw_sw[1];
        raw_btn[1] = raw_btn[0]; raw_btn[0] = bus.continue_button;
        raw_sw[1]  = raw_sw[0];  raw_sw[0]  = bus.switches;
        // Accepted edges become visible to the protocol one edge later.
        down_now = m_down_seen; up_now = m_up_seen;
        m_down_seen = 0; m_up_seen = 0;
        if (seen_btn != m_stable) begin
            m_run++;
            if (m_run == DEB) begin
                m_stable = seen_btn;
                m_run = 0;
                if (seen_btn) m_down_seen = 1; else m_up_seen = 1;
            end
        end else begin
            m_run = 0;
        end
        want = bus.is_input | bus.is_output;
        m_user = 0;
        case (m_phase)
            PH_IDLE: if (want) begin
                m_phase = PH_WANT_DOWN;
                if (bus.is_output) m_disp = bus.data_out;
            end else if (down_now) m_user = 1;
            PH_WANT_DOWN: if (!want) m_phase = PH_IDLE;
                else if (down_now) begin
                    m_phase = PH_WANT_UP;
                    if (bus.is_input) m_din = DW'(seen_sw);
                end
            PH_WANT_UP: if (!want) m_phase = PH_IDLE;
                else if (up_now) m_phase = PH_DONE;
            PH_DONE: if (!want) m_phase = PH_IDLE;
            default: m_phase = PH_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_tick();
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst, inp, outp;
        logic [DW-1:0] dout;
        logic [SW-1:0] sw;
        logic          btn;
        int            cycles;
        logic          conf, busy, user;
        logic [DW-1:0] din, disp;
    } vec_t;

    vec_t vec[$];

    task automatic check_outputs(input string tag, input logic conf, input logic busy,
                                 input logic user, input logic [DW-1:0] din,
                                 input logic [DW-1:0] disp);
        check({tag, ".confirmation"}, bus.confirmation, conf);
        check({tag, ".busy"}, bus.busy, busy);
        check({tag, ".is_user_request"}, bus.is_user_request, user);
        check({tag, ".data_in"}, bus.data_in, din);
        check({tag, ".display_value"}, bus.display_value, disp);
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.is_user_request === 1'b1) pulses++;
        end
    endtask

    initial begin
        int unsigned k;
        int          pulses;
        int          hold;

        bus.is_input = 0; bus.is_output = 0; bus.data_out = '0;
        bus.switches = '0; bus.continue_button = 0;

        //          rst in out dout          sw        btn cyc  conf busy user din           disp
        // output request
        vec.push_back('{1, 0, 0, 32'h0,        16'h0,    0, 2,  0, 0, 0, 32'h0,        32'h0});
        vec.push_back('{0, 0, 1, 32'hDEADBEEF, 16'h0,    0, 1,  0, 1, 0, 32'h0,        32'hDEADBEEF});
        vec.push_back('{0, 0, 1, 32'hDEADBEEF, 16'h0,    1, 7,  0, 1, 0, 32'h0,        32'hDEADBEEF});
        vec.push_back('{0, 0, 1, 32'hDEADBEEF, 16'h0,    0, 6,  0, 1, 0, 32'h0,        32'hDEADBEEF});
        vec.push_back('{0, 0, 1, 32'hDEADBEEF, 16'h0,    0, 1,  1, 1, 0, 32'h0,        32'hDEADBEEF});
        vec.push_back('{0, 0, 1, 32'hDEADBEEF, 16'h0,    0, 3,  1, 1, 0, 32'h0,        32'hDEADBEEF});
        vec.push_back('{0, 0, 0, 32'h0,        16'h0,    0, 1,  0, 0, 0, 32'h0,        32'hDEADBEEF});
        // input request
        vec.push_back('{0, 1, 0, 32'h0,        16'hA5C3, 0, 1,  0, 1, 0, 32'h0,        32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'hA5C3, 1, 7,  0, 1, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'hFFFF, 0, 7,  1, 1, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'hFFFF, 0, 2,  1, 1, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 0, 0, 32'h0,        16'hFFFF, 0, 1,  0, 0, 0, 32'h0000A5C3, 32'hDEADBEEF});
        // user request from idle
        vec.push_back('{0, 0, 0, 32'h0,        16'hFFFF, 1, 7,  0, 0, 1, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 0, 0, 32'h0,        16'hFFFF, 1, 1,  0, 0, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 0, 0, 32'h0,        16'hFFFF, 0, 8,  0, 0, 0, 32'h0000A5C3, 32'hDEADBEEF});
        // request coinciding with a press strobe
        vec.push_back('{0, 0, 0, 32'h0,        16'hFFFF, 1, 6,  0, 0, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'h1234, 1, 1,  0, 1, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'h1234, 1, 10, 0, 1, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'h1234, 0, 8,  0, 1, 0, 32'h0000A5C3, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'h1234, 1, 7,  0, 1, 0, 32'h00001234, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'h1234, 0, 7,  1, 1, 0, 32'h00001234, 32'hDEADBEEF});
        vec.push_back('{0, 0, 0, 32'h0,        16'h1234, 0, 1,  0, 0, 0, 32'h00001234, 32'hDEADBEEF});
        // abort in WAIT_RELEASE
        vec.push_back('{0, 1, 0, 32'h0,        16'h0F0F, 0, 1,  0, 1, 0, 32'h00001234, 32'hDEADBEEF});
        vec.push_back('{0, 1, 0, 32'h0,        16'h0F0F, 1, 7,  0, 1, 0, 32'h00000F0F, 32'hDEADBEEF});
        vec.push_back('{0, 0, 0, 32'h0,        16'h0F0F, 1, 1,  0, 0, 0, 32'h00000F0F, 32'hDEADBEEF});
        vec.push_back('{0, 0, 0, 32'h0,        16'h0F0F, 0, 10, 0, 0, 0, 32'h00000F0F, 32'hDEADBEEF});
        // input and output together
        vec.push_back('{0, 1, 1, 32'h12345678, 16'h8001, 0, 1,  0, 1, 0, 32'h00000F0F, 32'h12345678});
        vec.push_back('{0, 1, 1, 32'h12345678, 16'h8001, 1, 7,  0, 1, 0, 32'h00008001, 32'h12345678});
        vec.push_back('{0, 1, 1, 32'h12345678, 16'h8001, 0, 7,  1, 1, 0, 32'h00008001, 32'h12345678});
        vec.push_back('{0, 0, 0, 32'h0,        16'h8001, 0, 1,  0, 0, 0, 32'h00008001, 32'h12345678});

        @(negedge clk);
        foreach (vec[i]) begin
            rst = vec[i].rst; bus.is_input = vec[i].inp; bus.is_output = vec[i].outp;
            bus.data_out = vec[i].dout; bus.switches = vec[i].sw;
            bus.continue_button = vec[i].btn;
            repeat (vec[i].cycles) @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vec[i].conf, vec[i].busy, vec[i].user,
                          vec[i].din, vec[i].disp);
        end

        // Bouncing button in idle: exactly one user pulse once it settles high.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            bus.continue_button = ((i / 2) % 2) == 0;
            @(negedge clk);
            if (bus.is_user_request === 1'b1) pulses++;
        end
        bus.continue_button = 1;
        count_pulses(12, k);
        check("bounce_idle.pulses", pulses + k, 1);
        bus.continue_button = 0;
        repeat (10) @(negedge clk);

        // Bouncing press under an input request: one capture, no early confirm.
        bus.is_input = 1; bus.switches = 16'h0055;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            bus.continue_button = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        bus.continue_button = 1;
        repeat (12) @(negedge clk);
        check_outputs("bounce_req.held", 0, 1, 0, 32'h00000055, 32'h12345678);
        bus.continue_button = 0;
        repeat (6) @(negedge clk);
        check("bounce_req.pre_conf", bus.confirmation, 0);
        @(negedge clk);
        check("bounce_req.conf", bus.confirmation, 1);
        bus.is_input = 0;
        @(negedge clk);
        check("bounce_req.drop", bus.confirmation, 0);

        // Reset while in CONFIRM with the button held down again.
        bus.is_input = 1; bus.switches = 16'h3C3C;
        @(negedge clk);
        bus.continue_button = 1; repeat (7) @(negedge clk);
        bus.continue_button = 0; repeat (7) @(negedge clk);
        check("rst_confirm.conf", bus.confirmation, 1);
        check("rst_confirm.din", bus.data_in, 32'h00003C3C);
        bus.continue_button = 1;
        count_pulses(8, pulses);
        check("rst_confirm.ignored_press", pulses, 0);
        check("rst_confirm.still_conf", bus.confirmation, 1);
        #2 rst = 1;
        #1;
        check_outputs("async_reset", 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        bus.is_input = 0;
        rst = 0;
        count_pulses(10, pulses);
        check("rst_redebounce.pulses", pulses, 1);
        bus.continue_button = 0;
        repeat (8) @(negedge clk);

        // Randomized traffic against the reference model.
        hold = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_outputs("rnd", logic'(m_phase == PH_DONE), logic'(m_phase != PH_IDLE),
                          m_user, m_din, m_disp);
            if (rst) rst = 0;
            else if ($urandom_range(0, 799) == 0) rst = 1;
            if (hold == 0) begin
                bus.continue_button = ~bus.continue_button;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 15);
            end else begin
                hold--;
            end
            if (!(bus.is_input | bus.is_output)) begin
                if ($urandom_range(0, 7) == 0) begin
                    k = $urandom_range(1, 3);
                    bus.is_input = k[0]; bus.is_output = k[1];
                    bus.data_out = $urandom;
                end
            end else if (m_phase == PH_DONE) begin
                if ($urandom_range(0, 2) == 0) begin bus.is_input = 0; bus.is_output = 0; end
            end else if ($urandom_range(0, 149) == 0) begin
                bus.is_input = 0; bus.is_output = 0;
            end
            if ($urandom_range(0, 15) == 0) bus.switches = SW'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
